alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, meaning the number of cycles the latched operands are held on the shared ALU before the result is captured; the legal range is 1..15.
REQ-002 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 Port reset_n, input, 1, meaning the reset, asynchronous and active-low.
REQ-004 Port req0, input, 1, meaning the port-0 request; held high until done0.
REQ-005 Port op0, input, 6, meaning the port-0 ALU function code.
REQ-006 Port a0, input, 32, meaning the port-0 operand a.
REQ-007 Port b0, input, 32, meaning the port-0 operand b.
REQ-008 Ports req1, op1, a1 and b1, inputs, 1/6/32/32, meaning the same as port 0 for port 1.
REQ-009 Port done0, output, 1, meaning a one-cycle pulse that marks port-0 completion.
REQ-010 Port done1, output, 1, meaning a one-cycle pulse that marks port-1 completion.
REQ-011 Port result, output, 32, meaning the registered ALU result of the last completed operation.
REQ-012 Port zero, output, 1, meaning the registered ALU zero flag of the last completed operation.
REQ-013 Port busy, output, 1, meaning high whenever the state is not IDLE.
REQ-014 Port alu_op, output, 6, meaning the function code to the shared ALU.
REQ-015 Ports alu_a and alu_b, outputs, 32 each, meaning the operands to the shared ALU.
REQ-016 Port alu_result, input, 32, meaning the combinational result from the shared ALU.
REQ-017 Port alu_zero, input, 1, meaning the combinational zero flag from the shared ALU.

Function
REQ-018 The controller SHALL be a three-state machine with states IDLE, EXEC and RESP.
REQ-019 In IDLE with req0 or req1 high, the block SHALL select a winner, latch that port's op/a/b into internal registers, load cnt = EXEC_CYCLES-1 and enter EXEC.
REQ-020 Arbitration SHALL work as follows: a sole requester wins; with both requesting, the port not recorded in last_grant wins (round-robin).
REQ-021 alu_op, alu_a and alu_b SHALL be driven only from the latched registers, never combinationally from the requester inputs.
REQ-022 In EXEC, cnt SHALL decrement each cycle; when cnt==0, result<=alu_result, zero<=alu_zero and the state SHALL become RESP.
REQ-023 In RESP, the done pulse of the owning port SHALL be high for exactly one cycle, last_grant<=owner, and the state SHALL return to IDLE.
REQ-024 Latency: with req sampled high in IDLE in cycle N, done SHALL be high in cycle N+EXEC_CYCLES+1, i.e. N+2 at the default.
REQ-025 Throughput: under continuous two-port load, grants SHALL alternate, with one completion every EXEC_CYCLES+2 cycles.
REQ-026 A request that arrives while busy SHALL wait, and SHALL NOT corrupt the latched operands.
REQ-027 If the owner drops req mid-operation, the operation SHALL still complete and done SHALL still pulse.
REQ-028 A req still high in the IDLE cycle after done SHALL be treated as a new request.
REQ-029 result and zero SHALL hold their values until the next capture; alu_op, alu_a and alu_b SHALL hold their last latched values while in IDLE.
REQ-030 done0 and done1 SHALL never both be high in the same cycle.

Reset
REQ-031 reset_n low SHALL force, immediately and regardless of clk, state=IDLE, done0=done1=0, busy=0, result=0, zero=0, alu_op=0, alu_a=0, alu_b=0, cnt=0 and last_grant=1, so that port 0 wins the first tie.
REQ-032 A reset asserted during EXEC or RESP SHALL abort the operation: no done pulse, and no result update after release.
REQ-033 After reset_n rises, the first arbitration SHALL occur on the first clk edge at which a req is high.

Verification
REQ-034 Scenario: single request, defaults; req0=1, op0=6'b100000 (add), a0=5, b0=7 in cycle 0 -> done0 high in cycle 2, result=12, zero=0, done1=0.
REQ-035 Scenario: simultaneous requests immediately after reset; req0 with op 6'b100010 (sub), a0=9, b0=9; req1 with op 6'b100100 (AND), a1=32'hF0, b1=32'h3C -> port 0 served first (result=0, zero=1), then port 1 (result=32'h30), done pulses 3 cycles apart.
REQ-036 Scenario: both req held continuously for 8 operations -> grant order 0,1,0,1,...; exactly 4 done0 and 4 done1 pulses.
REQ-037 Scenario: EXEC_CYCLES=4; req1 with op 6'b100101 (OR), a1=1, b1=2 in cycle 0 -> busy for cycles 1-5, done1 in cycle 5, result=3; a1 changed in cycle 2 does not alter the result.
REQ-038 Scenario: reset_n pulsed low during EXEC -> no done pulse, busy=0 and result=0 immediately; the next tie goes to port 0.
REQ-039 Scenario: req0 dropped in the cycle after grant -> done0 still pulses once and result is updated.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports and the shared-ALU hookup for alu_arbiter.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if;
  logic        req0;
  logic [5:0]  op0;
  logic [31:0] a0;
  logic [31:0] b0;
  logic        req1;
  logic [5:0]  op1;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        done0;
  logic        done1;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic [5:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1, alu_result, alu_zero,
    output done0, done1, result, zero, busy, alu_op, alu_a, alu_b
  );

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1, alu_result, alu_zero,
    input  done0, done1, result, zero, busy, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter letting two requesters share one combinational ALU.
// Operands are latched at grant so the ALU never sees live requester inputs.
//
// state | meaning
// IDLE  | waiting for req0/req1, ALU operands hold the last latched values
// EXEC  | latched operands on the ALU, cnt counts down to the capture cycle
// RESP  | result captured, owner's done pulses, last grant recorded
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input logic       clk,
  input logic       reset_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  stateT      state;
  logic [3:0] cnt;
  logic       owner;
  logic       lastGrant;
  logic       grantPort;

  // Sole requester wins; on a tie the port not served last goes first.
  assign grantPort = (bus.req0 && bus.req1) ? ~lastGrant : bus.req1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      lastGrant  <= 1'b1;
      bus.done0  <= 1'b0;
      bus.done1  <= 1'b0;
      bus.busy   <= 1'b0;
      bus.result <= 32'd0;
      bus.zero   <= 1'b0;
      bus.alu_op <= 6'd0;
      bus.alu_a  <= 32'd0;
      bus.alu_b  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner      <= grantPort;
            bus.alu_op <= grantPort ? bus.op1 : bus.op0;
            bus.alu_a  <= grantPort ? bus.a1  : bus.a0;
            bus.alu_b  <= grantPort ? bus.b1  : bus.b0;
            cnt        <= 4'(EXEC_CYCLES - 1);
            bus.busy   <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            bus.result <= bus.alu_result;
            bus.zero   <= bus.alu_zero;
            bus.done0  <= ~owner;
            bus.done1  <= owner;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.busy  <= 1'b0;
          lastGrant <= owner;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
